// File: rtl/ram_rd_stream_pkg.sv
// Shared types and constants for the RAM read-stream client.
package ram_rd_stream_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/ram_rd_stream_stream_fifo2.sv
// Two-entry FIFO holding {last, data}. A push and a pop in the same cycle are allowed.
module stream_fifo2
  import ram_rd_stream_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  logic [WIDTH:0] push_data,
  input  logic           pop,
  output logic [WIDTH:0] head,
  output logic           full,
  output logic           empty,
  output logic [1:0]     count
);

  logic [WIDTH:0] mem [BUF_DEPTH];
  logic           wr_ptr;
  logic           rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == 2'(BUF_DEPTH));
  assign empty   = (count == 2'd0);
  assign do_pop  = pop && !empty;
  // When full, a same-cycle pop frees the head slot that the write pointer points at.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end else begin
        wr_ptr      <= wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end else begin
        rd_ptr <= rd_ptr;
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/ram_rd_stream.sv
// Walks an address range on a 1-cycle-latency RAM read port and presents the words
// as a valid/ready stream through a 2-entry buffer.
module ram_rd_stream
  import ram_rd_stream_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [$clog2(DEPTH)-1:0] base_addr_i,
  input  logic [$clog2(DEPTH):0]   len_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     rd_en_o,
  output logic [$clog2(DEPTH)-1:0] rd_addr_o,
  input  logic [WIDTH-1:0]         rd_data_i,
  output logic                     out_valid_o,
  output logic [WIDTH-1:0]         out_data_o,
  output logic                     out_last_o,
  input  logic                     out_ready_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  state_t         state_r;
  logic [CW-1:0]  len_r;
  logic [CW-1:0]  issued_r;
  logic [CW-1:0]  beats_r;
  logic           inflight_r;
  logic           last_pipe_r;

  logic           pop_s;
  logic           credit_ok_s;
  logic           issue_last_s;
  logic [WIDTH:0] head_s;
  logic           full_s;
  logic           empty_s;
  logic [1:0]     count_s;

  assign pop_s        = out_valid_o && out_ready_i;
  // credit = 2 - count - inflight + pop > 0, rearranged to stay unsigned.
  assign credit_ok_s  = ({1'b0, count_s} + {2'b00, inflight_r}) < (3'd2 + {2'b00, pop_s});
  assign issue_last_s = (issued_r + CW'(1)) == len_r;
  assign rd_en_o      = (state_r == RUN) && credit_ok_s && (issued_r < len_r);

  assign out_valid_o  = !empty_s;
  assign out_data_o   = head_s[WIDTH-1:0];
  assign out_last_o   = head_s[WIDTH] && !empty_s;

  stream_fifo2 #(.WIDTH(WIDTH)) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (inflight_r),
    .push_data ({last_pipe_r, rd_data_i}),
    .pop       (pop_s),
    .head      (head_s),
    .full      (full_s),
    .empty     (empty_s),
    .count     (count_s)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r     <= IDLE;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      rd_addr_o   <= '0;
      len_r       <= '0;
      issued_r    <= '0;
      beats_r     <= '0;
      inflight_r  <= 1'b0;
      last_pipe_r <= 1'b0;
    end else begin
      inflight_r  <= rd_en_o;
      last_pipe_r <= rd_en_o && issue_last_s;
      done_o      <= 1'b0;
      if (pop_s) begin
        beats_r <= beats_r + CW'(1);
      end else begin
        beats_r <= beats_r;
      end
      case (state_r)
        IDLE: begin
          if (start_i) begin
            if (len_i != '0) begin
              len_r     <= len_i;
              rd_addr_o <= base_addr_i;
              issued_r  <= '0;
              beats_r   <= '0;
              busy_o    <= 1'b1;
              state_r   <= RUN;
            end else begin
              done_o    <= 1'b1;
              state_r   <= DONE;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          if (rd_en_o) begin
            issued_r  <= issued_r + CW'(1);
            rd_addr_o <= (rd_addr_o == AW'(DEPTH - 1)) ? '0 : rd_addr_o + AW'(1);
            state_r   <= issue_last_s ? DRAIN : RUN;
          end else begin
            state_r   <= RUN;
          end
        end
        DRAIN: begin
          if (pop_s && out_last_o && ((beats_r + CW'(1)) == len_r)) begin
            done_o  <= 1'b1;
            busy_o  <= 1'b0;
            state_r <= DONE;
          end else begin
            state_r <= DRAIN;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
